// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply job controller.
//   mm_state_e    : controller state encoding
//   MM_*_DEF      : default matrix dimension and the N*N-derived constants
//   mm_last_idx() : last linear index of an N x N matrix (N*N-1)
package matmul_pkg;

   localparam int unsigned MM_DIM_DEF    = 8;
   localparam int unsigned MM_WORDS_DEF  = MM_DIM_DEF * MM_DIM_DEF;
   localparam int unsigned MM_ADDR_W_DEF = $clog2(MM_WORDS_DEF);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_A   = 3'd1,
      ST_LOAD_B   = 3'd2,
      ST_RUN      = 3'd3,
      ST_WAIT_ENG = 3'd4,
      ST_DRAIN    = 3'd5,
      ST_DONE     = 3'd6
   } mm_state_e;

   function automatic int unsigned mm_last_idx(input int unsigned dim);
      return dim * dim - 1;
   endfunction

endpackage

// File: rtl/ctrl_addr_cnt.sv
// Address counter shared by the operand-load and result-drain paths.
//   CLK, rst : clock, asynchronous active-high reset
//   en       : advance by one (wraps to 0 after LAST)
//   clr      : synchronous clear, has priority over en
//   cnt      : current count
//   wrap     : high in the cycle an enabled count sits at LAST
module ctrl_addr_cnt #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned LAST  = 63
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

   assign wrap = en && (cnt == LAST_V);

   always_ff @(posedge CLK or posedge rst) begin
      if (rst)       cnt <= '0;
      else if (clr)  cnt <= '0;
      else if (en)   cnt <= wrap ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/matmul_ctrl.sv
// Job controller for a matrix-multiply engine: streams A then B operands
// into memory, kicks the engine, waits for it to finish, then streams C out.
//   CLK, rst                      : clock, asynchronous active-high reset
//   cmd_start / cmd_ready / done  : job request, idle indication, end pulse
//   in_valid/in_ready/in_data     : operand stream (A words, then B words)
//   a_we/b_we/wr_addr/wr_data     : A/B memory write port
//   eng_start / eng_busy          : engine kick pulse / engine busy status
//   c_rd_addr / c_rd_data         : C memory read port (1-cycle latency)
//   out_valid/out_ready/out_data  : result stream
//   cycle_count                   : job cycle counter, only when
//                                   MATMUL_CTRL_PERF_EN is defined
//
// state       | meaning
// ------------+-------------------------------------------------
// ST_IDLE     | waiting for cmd_start
// ST_LOAD_A   | accepting N*N words into A memory
// ST_LOAD_B   | accepting N*N words into B memory
// ST_RUN      | one-cycle engine start pulse
// ST_WAIT_ENG | waiting for engine busy to rise and then fall
// ST_DRAIN    | reading C memory out, one word per two cycles
// ST_DONE     | one-cycle done pulse
module matmul_ctrl
   import matmul_pkg::*;
#(
   parameter int unsigned MATRIX_DIM = MM_DIM_DEF,
   parameter int unsigned ADDR_WIDTH = MM_ADDR_W_DEF,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 32
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  cmd_start,
   output logic                  cmd_ready,
   output logic                  done,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  a_we,
   output logic                  b_we,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  eng_start,
   input  logic                  eng_busy,
   output logic [ADDR_WIDTH-1:0] c_rd_addr,
   input  logic [ACC_WIDTH-1:0]  c_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_data
`ifdef MATMUL_CTRL_PERF_EN
   ,
   output logic [31:0]           cycle_count
`endif
);

   localparam int unsigned LAST_IDX = mm_last_idx(MATRIX_DIM);

   mm_state_e             state_q, state_d;
   logic                  seen_busy_q;
   logic                  out_valid_q;
   logic                  load_st;
   logic                  ld_en, ld_clr, ld_wrap;
   logic                  dr_en, dr_clr, dr_wrap;
   logic [ADDR_WIDTH-1:0] ld_cnt, dr_cnt;

   assign load_st = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
   assign ld_en   = load_st && in_valid;
   assign ld_clr  = (state_q == ST_IDLE);
   assign dr_en   = (state_q == ST_DRAIN) && out_valid_q && out_ready;
   assign dr_clr  = (state_q == ST_IDLE);

   ctrl_addr_cnt #(.WIDTH(ADDR_WIDTH), .LAST(LAST_IDX)) u_ld_cnt (
      .CLK  (CLK),
      .rst  (rst),
      .en   (ld_en),
      .clr  (ld_clr),
      .cnt  (ld_cnt),
      .wrap (ld_wrap)
   );

   ctrl_addr_cnt #(.WIDTH(ADDR_WIDTH), .LAST(LAST_IDX)) u_dr_cnt (
      .CLK  (CLK),
      .rst  (rst),
      .en   (dr_en),
      .clr  (dr_clr),
      .cnt  (dr_cnt),
      .wrap (dr_wrap)
   );

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         seen_busy_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         seen_busy_q <= (state_q == ST_WAIT_ENG) && (seen_busy_q || eng_busy);
         // Valid rises the cycle after a fresh address is presented (the C
         // memory's read latency) and drops for one cycle after each
         // handshake so the next address can be read.
         out_valid_q <= (state_q == ST_DRAIN) && (out_valid_q ? !out_ready : 1'b1);
      end
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      a_we      = 1'b0;
      b_we      = 1'b0;
      eng_start = 1'b0;
      done      = 1'b0;
      wr_addr   = ld_cnt;
      wr_data   = in_data;
      c_rd_addr = dr_cnt;
      out_valid = out_valid_q;
      // c_rd_data is the memory's registered output and stays stable while
      // the drain address is held, so it is forwarded only while valid.
      out_data  = out_valid_q ? c_rd_data : '0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_start) state_d = ST_LOAD_A;
         end
         ST_LOAD_A: begin
            in_ready = 1'b1;
            a_we     = in_valid;
            if (ld_wrap) state_d = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            in_ready = 1'b1;
            b_we     = in_valid;
            if (ld_wrap) state_d = ST_RUN;
         end
         ST_RUN: begin
            eng_start = 1'b1;
            state_d   = ST_WAIT_ENG;
         end
         ST_WAIT_ENG: begin
            if (seen_busy_q && !eng_busy) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (dr_wrap) state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef MATMUL_CTRL_PERF_EN
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         cycle_count <= '0;
      end else if (state_q == ST_IDLE) begin
         if (state_d != ST_IDLE) cycle_count <= '0;
      end else if (cycle_count != '1) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl (N=8). Random operands, random input
// stalls, a behavioural engine and C memory; expectations come from the job
// rules: word i of the stream lands in A[i] or B[i-64], the engine is kicked
// once, drain starts only after busy has risen and fallen, C comes out in
// address order. Build with MATMUL_CTRL_PERF_EN to also check cycle_count.
module tb_matmul_ctrl;

   localparam int N       = 8;
   localparam int WORDS   = N * N;
   localparam int AW      = 6;
   localparam int DW      = 8;
   localparam int CW      = 32;
   localparam int ENG_LAT = 512;

   logic          CLK = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_start = 1'b0;
   logic          cmd_ready, done;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          a_we, b_we;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          eng_start;
   logic          eng_busy;
   logic [AW-1:0] c_rd_addr;
   logic [CW-1:0] c_rd_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [CW-1:0] out_data;
`ifdef MATMUL_CTRL_PERF_EN
   logic [31:0]   cycle_count;
`endif

   matmul_ctrl #(
      .MATRIX_DIM (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (CW)
   ) dut (
      .CLK        (CLK),
      .rst        (rst),
      .cmd_start  (cmd_start),
      .cmd_ready  (cmd_ready),
      .done       (done),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .a_we       (a_we),
      .b_we       (b_we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .eng_start  (eng_start),
      .eng_busy   (eng_busy),
      .c_rd_addr  (c_rd_addr),
      .c_rd_data  (c_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
`ifdef MATMUL_CTRL_PERF_EN
      ,
      .cycle_count(cycle_count)
`endif
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge CLK) cyc++;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Memory images: A/B capture from the write port, C is preloaded.
   logic [DW-1:0] amem [WORDS];
   logic [DW-1:0] bmem [WORDS];
   logic [CW-1:0] cmem [WORDS];

   always @(posedge CLK) begin
      if (!rst && a_we) amem[wr_addr] <= wr_data;
      if (!rst && b_we) bmem[wr_addr] <= wr_data;
      c_rd_data <= cmem[c_rd_addr];
   end

   // Engine: busy rises one cycle after it sees the start pulse and stays
   // high for ENG_LAT cycles.
   logic eng_pend;
   int   eng_cnt;
   always @(posedge CLK or posedge rst) begin
      if (rst) begin
         eng_busy <= 1'b0;
         eng_pend <= 1'b0;
         eng_cnt  <= 0;
      end else if (eng_start) begin
         eng_pend <= 1'b1;
      end else if (eng_pend) begin
         eng_pend <= 1'b0;
         eng_busy <= 1'b1;
         eng_cnt  <= ENG_LAT - 1;
      end else if (eng_busy) begin
         if (eng_cnt == 0) eng_busy <= 1'b0;
         else              eng_cnt  <= eng_cnt - 1;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_strobes"},
                {cmd_ready, in_ready, a_we, b_we, eng_start, out_valid, done}, 7'b1000000);
      check_val({tag, "_addr_data"}, {wr_addr, c_rd_addr, out_data}, '0);
`ifdef MATMUL_CTRL_PERF_EN
      check_val({tag, "_cycle_count"}, cycle_count, 0);
`endif
   endtask

   // Entered at posedge+1 of the first LOAD_A cycle; returns at posedge+1
   // of the RUN cycle.
   task automatic load_phase(input bit stalls);
      logic [DW-1:0] words [2*WORDS];
      int idx   = 0;
      int guard = 0;
      int bad   = 0;
      for (int i = 0; i < 2*WORDS; i++) words[i] = DW'($urandom);
      for (int i = 0; i < WORDS; i++) begin
         amem[i] = 'x;
         bmem[i] = 'x;
      end
      while (idx < 2*WORDS && guard < 4000) begin
         in_valid  = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data   = words[idx];
         cmd_start = 1'($urandom_range(0, 1));
         @(negedge CLK);
         if (in_valid)
            check_val("load_wr", {in_ready, a_we, b_we, wr_addr, wr_data},
                      {1'b1, idx < WORDS, idx >= WORDS, AW'(idx % WORDS), words[idx]});
         else
            check_val("stall_wr", {in_ready, a_we, b_we}, 3'b100);
         @(posedge CLK);
         #1;
         if (in_valid) idx++;
         guard++;
      end
      in_valid  = 1'b0;
      cmd_start = 1'b0;
      if (idx != 2*WORDS) check_val("load_timeout", idx, 2*WORDS);
      for (int i = 0; i < WORDS; i++)
         if (amem[i] !== words[i] || bmem[i] !== words[i+WORDS]) bad++;
      check_val("mem_image", bad, 0);
   endtask

   // Returns at the negedge where word 0 is first valid, or after a reset.
   task automatic wait_phase(input bit abort, output bit ok);
      int starts  = 0;
      int t_start = -1;
      int guard   = 0;
      ok = 1'b0;
      while (guard < 2000) begin
         @(negedge CLK);
         if (eng_start) begin
            starts++;
            t_start = cyc;
            check_val("run_quiet", {cmd_ready, in_ready, a_we, b_we, out_valid}, 5'b0);
         end
         if (out_valid) break;
         if (abort && t_start >= 0 && cyc == t_start + 100) begin
            check_val("busy_before_abort", eng_busy, 1);
            rst = 1'b1;
            #1;
            check_reset_outputs("rst_wait");
            @(posedge CLK);
            @(negedge CLK);
            rst = 1'b0;
            check_reset_outputs("rst_release");
            return;
         end
         guard++;
      end
      check_val("eng_start_cnt", starts, 1);
      check_val("drain_latency", cyc - t_start, ENG_LAT + 4);
      ok = (guard < 2000);
   endtask

   task automatic drain_phase(input bit hold5);
      int last_hs = -1;
      for (int w = 0; w < WORDS; w++) begin
         int guard = 0;
         out_ready = !(hold5 && w == 5);
         while (!out_valid && guard < 8) begin
            @(negedge CLK);
            guard++;
         end
         if (!out_valid) begin
            check_val("out_valid_timeout", out_valid, 1);
            out_ready = 1'b1;
            return;
         end
         if (hold5 && w == 5) begin
            for (int k = 0; k < 10; k++) begin
               check_val("hold_word5", {out_valid, out_data}, {1'b1, cmem[5]});
               @(negedge CLK);
            end
            out_ready = 1'b1;
         end
         check_val("out_word", {out_valid, out_data, c_rd_addr}, {1'b1, cmem[w], AW'(w)});
         if (!hold5 && last_hs >= 0) check_val("out_gap", cyc - last_hs, 2);
         last_hs = cyc;
         @(negedge CLK);
         check_val("valid_drop", out_valid, 0);
      end
      check_val("done_pulse", {done, cmd_ready}, 2'b10);
      @(negedge CLK);
      check_val("idle_after", {done, cmd_ready, eng_start, in_ready}, 4'b0100);
   endtask

   task automatic run_job(input bit stalls, input bit hold5, input bit abort);
      bit ok;
      for (int i = 0; i < WORDS; i++) cmem[i] = CW'($urandom);
      @(negedge CLK);
      check_val("idle_ready", {cmd_ready, in_ready}, 2'b10);
      cmd_start = 1'b1;
      @(posedge CLK);
      #1;
      cmd_start = 1'b0;
`ifdef MATMUL_CTRL_PERF_EN
      check_val("cycle_count_clear", cycle_count, 0);
`endif
      load_phase(stalls);
      wait_phase(abort, ok);
      if (!ok) return;
      drain_phase(hold5);
`ifdef MATMUL_CTRL_PERF_EN
      if (!stalls && !hold5) check_val("cycle_count", cycle_count, 128 + 1 + 514 + 128 + 1);
      begin
         logic [31:0] snap;
         snap = cycle_count;
         repeat (3) @(negedge CLK);
         check_val("cycle_count_hold", cycle_count, snap);
      end
`endif
   endtask

   initial begin
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_init");
      #20;
      @(negedge CLK);
      rst = 1'b0;
      run_job(1'b0, 1'b0, 1'b0);
      run_job(1'b1, 1'b1, 1'b0);
      run_job(1'b1, 1'b0, 1'b1);
      run_job(1'b1, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter MATRIX_DIM, default 8: square matrix dimension N.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: operand/result memory address width, equal to clog2(N*N).
REQ-003 SHALL have parameter DATA_WIDTH, default 8: operand word width.
REQ-004 SHALL have parameter ACC_WIDTH, default 32: result word width.
REQ-005 SHALL have port CLK, input, 1 bit: clock; all logic is rising-edge triggered.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port cmd_start, input, 1 bit: job request, sampled only in IDLE.
REQ-008 SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at job end.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_WIDTH): operand load stream.
REQ-011 SHALL have ports a_we (output, 1), b_we (output, 1), wr_addr (output, ADDR_WIDTH) and wr_data (output, DATA_WIDTH): A/B memory write port.
REQ-012 SHALL have ports eng_start (output, 1) and eng_busy (input, 1): compute-engine start pulse and engine state bit (1 = busy).
REQ-013 SHALL have ports c_rd_addr (output, ADDR_WIDTH) and c_rd_data (input, ACC_WIDTH): C memory read port with 1-cycle read latency.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, ACC_WIDTH): result stream.

Function
REQ-015 SHALL implement the states IDLE, LOAD_A, LOAD_B, RUN, WAIT_ENG, DRAIN and DONE.
REQ-016 SHALL go from IDLE to LOAD_A on cmd_start=1; cmd_start SHALL be ignored in every other state.
REQ-017 In LOAD_A/LOAD_B: in_ready=1; on each in_valid&in_ready, a_we (LOAD_A) or b_we (LOAD_B) SHALL equal 1 in the same cycle, with wr_addr = load count and wr_data = in_data (combinational).
REQ-018 The load count SHALL increment per accepted word, wrap to 0 after N*N-1, and move the state LOAD_A->LOAD_B and LOAD_B->RUN on that wrap.
REQ-019 in_valid=0 SHALL stall loading indefinitely, with no write and no count change.
REQ-020 RUN SHALL last one cycle with eng_start=1, then go to WAIT_ENG.
REQ-021 WAIT_ENG SHALL set an internal seen_busy flag on eng_busy=1 and go to DRAIN on the first cycle with seen_busy=1 and eng_busy=0.
REQ-022 eng_busy=0 before seen_busy is set SHALL NOT end WAIT_ENG.
REQ-023 In DRAIN: c_rd_addr = drain count; out_valid SHALL rise one cycle after a new address is presented, with out_data = c_rd_data registered, and SHALL hold until out_ready=1.
REQ-024 On each out_valid&out_ready, the drain count SHALL increment and out_valid SHALL drop for one cycle; throughput is 1 word per 2 cycles.
REQ-025 The handshake on drain count N*N-1 SHALL go to DONE; DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-026 in_ready SHALL be 0 outside LOAD states, and a_we, b_we and eng_start SHALL be 0 outside their stated states.

Reset
REQ-027 On rst=1, the block SHALL immediately be in IDLE with counts=0, seen_busy=0, and outputs in_ready, a_we, b_we, eng_start, out_valid, done = 0, cmd_ready=1, wr_addr, c_rd_addr, out_data = 0.
REQ-028 rst mid-job SHALL abandon the job; partial memory contents are don't-care.

Configuration
REQ-029 With MATMUL_CTRL_PERF_EN defined, the block SHALL add output cycle_count[31:0], which resets to 0, clears on leaving IDLE, increments every non-IDLE cycle, saturates at all-ones, and holds its value in IDLE.
REQ-030 Without MATMUL_CTRL_PERF_EN, the cycle_count port and its logic SHALL be absent.

Structure
REQ-031 The state enumeration and the N*N-derived constants SHALL reside in shared package matmul_pkg.
REQ-032 Load and drain counters SHALL use one sub-module, ctrl_addr_cnt, with enable, synchronous clear and a wrap flag.

Verification (N=8)
REQ-033 The bench SHALL apply cmd_start, then stream 128 words with in_valid=1 held -> expect a_we on addresses 0..63, then b_we on addresses 0..63, then eng_start pulsed exactly once.
REQ-034 The bench SHALL drop in_valid randomly during load -> expect no writes while it is low and the same final memory image.
REQ-035 The bench SHALL model the engine as eng_busy rising 1 cycle after eng_start and falling 512 cycles later -> expect DRAIN entered on the falling edge, not before.
REQ-036 The bench SHALL hold out_ready=0 for 10 cycles on word 5 -> expect out_valid held with out_data stable, then 64 words emitted in order, done pulsed once and cmd_ready=1 after.
REQ-037 The bench SHALL assert rst during WAIT_ENG -> expect IDLE, cmd_ready=1, all strobes 0, and a subsequent job completing normally.
REQ-038 With MATMUL_CTRL_PERF_EN and zero stalls, the bench SHALL expect cycle_count = 128+1+514+128+1.
